// File: rtl/pry_arb_rr.sv
// Round-robin arbiter with rightmost-priority selection.
// The winner is registered as one-hot plus binary index behind a valid/ready handshake.
// A rotating mask passes only the requests strictly above the last winner.
// When no masked request is active, selection falls back to the unmasked vector (wrap).
module pry_arb_rr #(
  parameter  int unsigned WIDTH     = 8,
  localparam int unsigned WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req,
  input  logic                 lck,
  output logic [WIDTH-1:0]     gnt_oht,
  output logic [WIDTH_LOG-1:0] gnt_bin,
  output logic                 gnt_vld,
  input  logic                 gnt_rdy
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0]     msk_q, msk_d;
  logic [WIDTH-1:0]     lst_q, lst_d;
  logic [WIDTH-1:0]     oht_d;
  logic [WIDTH_LOG-1:0] bin_d;
  logic                 vld_d;

  logic [WIDTH-1:0]     req_m;
  logic [WIDTH-1:0]     sel_m, sel_u, sel;
  logic [WIDTH_LOG-1:0] sel_bin;
  logic                 lock_hit;
  logic                 ld;

  // Select the winner: locked re-grant, else rightmost masked request, else rightmost request.
  always_comb begin
    req_m    = req & msk_q;
    lock_hit = lck & (|(req & lst_q));
    // x & -x isolates the rightmost set bit; the carry out of WIDTH bits is dropped.
    sel_m    = req_m & (~req_m + One);
    sel_u    = req & (~req + One);
    if (lock_hit) begin
      sel = lst_q;
    end else if (|req_m) begin
      sel = sel_m;
    end else begin
      sel = sel_u;
    end
  end

  // Encode the one-hot selection by OR-ing the index of every set bit.
  always_comb begin
    sel_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel[i]) begin
        sel_bin = sel_bin | i[WIDTH_LOG-1:0];
      end
    end
  end

  // Compute the next state: load when the output register is empty or being consumed.
  always_comb begin
    ld    = ~gnt_vld | gnt_rdy;
    msk_d = msk_q;
    lst_d = lst_q;
    oht_d = gnt_oht;
    bin_d = gnt_bin;
    vld_d = gnt_vld;
    if (ld) begin
      if (|req) begin
        oht_d = sel;
        bin_d = sel_bin;
        vld_d = 1'b1;
        lst_d = sel;
        // Keep only bits strictly above the winner; the top winner yields 0, forcing a wrap.
        msk_d = ~((sel << 1) - One);
      end else begin
        oht_d = '0;
        vld_d = 1'b0;
      end
    end
  end

  // Hold the grant, mask and last-winner state; reset drops any pending grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_oht <= '0;
      gnt_bin <= '0;
      gnt_vld <= 1'b0;
      msk_q   <= '1;
      lst_q   <= '0;
    end else begin
      gnt_oht <= oht_d;
      gnt_bin <= bin_d;
      gnt_vld <= vld_d;
      msk_q   <= msk_d;
      lst_q   <= lst_d;
    end
  end

endmodule

// File: tb/tb_pry_arb_rr.sv
// Self-checking bench for pry_arb_rr at WIDTH=4, with directed scenarios and random traffic.
// The reference model tracks the last winner's index and searches upward from it, wrapping.
module tb_pry_arb_rr;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] req;
  logic         lck;
  logic [W-1:0] gnt_oht;
  logic [1:0]   gnt_bin;
  logic         gnt_vld;
  logic         gnt_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [W-1:0] m_oht;
  logic [1:0]   m_bin;
  logic         m_vld;
  int           m_last;  // index of the last winner, -1 when none since reset

  pry_arb_rr #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .lck     (lck),
    .gnt_oht (gnt_oht),
    .gnt_bin (gnt_bin),
    .gnt_vld (gnt_vld),
    .gnt_rdy (gnt_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_oht  = '0;
    m_bin  = '0;
    m_vld  = 1'b0;
    m_last = -1;
  endtask

  // Advance one clock edge, updating the model from the inputs sampled at that edge.
  task automatic tick();
    int sel;
    sel = -1;
    if (rst_n === 1'b1 && (!m_vld || gnt_rdy)) begin
      if (req != '0) begin
        if (lck && m_last >= 0 && req[m_last]) begin
          sel = m_last;
        end else begin
          for (int i = m_last + 1; i < W; i++) if (sel < 0 && req[i]) sel = i;
          for (int i = 0; i < W; i++) if (sel < 0 && req[i]) sel = i;
        end
        m_oht  = W'(1) << sel;
        m_bin  = sel[1:0];
        m_vld  = 1'b1;
        m_last = sel;
      end else begin
        m_oht = '0;
        m_vld = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req     = '0;
    lck     = 1'b0;
    gnt_rdy = 1'b1;
    rst_n   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req     = '0;
    lck     = 1'b0;
    gnt_rdy = 1'b1;
    rst_n   = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (gnt_oht !== '0 || gnt_bin !== '0 || gnt_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: oht=%b bin=%0d vld=%b, want 0 0 0", gnt_oht, gnt_bin, gnt_vld);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (gnt_oht !== '0 || gnt_bin !== '0 || gnt_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_c%0d: oht=%b bin=%0d vld=%b, want 0 0 0", c, gnt_oht, gnt_bin,
                 gnt_vld);
      end
    end
  endtask

  task automatic test_fairness();
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    req = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (gnt_vld !== 1'b1 || gnt_bin !== 2'(exp_seq[c]) || !$onehot(gnt_oht) ||
          gnt_oht !== (W'(1) << exp_seq[c]) || m_bin !== 2'(exp_seq[c])) begin
        n_fail++;
        $display("FAIL fairness_c%0d: bin=%0d oht=%b vld=%b model=%0d, want bin %0d", c,
                 gnt_bin, gnt_oht, gnt_vld, m_bin, exp_seq[c]);
      end
    end
  endtask

  task automatic test_mask_wrap();
    logic [W-1:0] reqs [4] = '{4'b1010, 4'b0011, 4'b1000, 4'b1001};
    int           exps [4] = '{1, 0, 3, 0};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      req = reqs[c];
      tick();
      n_checks++;
      if (gnt_vld !== 1'b1 || gnt_bin !== 2'(exps[c]) || gnt_oht !== (W'(1) << exps[c])) begin
        n_fail++;
        $display("FAIL mask_wrap_%0d: req=%b bin=%0d oht=%b vld=%b, want bin %0d", c, reqs[c],
                 gnt_bin, gnt_oht, gnt_vld, exps[c]);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    req = 4'b0100;
    tick();
    gnt_rdy = 1'b0;
    req     = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (gnt_oht !== 4'b0100 || gnt_vld !== 1'b1 || gnt_bin !== 2'd2) begin
        n_fail++;
        $display("FAIL stall_hold_c%0d: oht=%b bin=%0d vld=%b, want 0100 2 1", c, gnt_oht,
                 gnt_bin, gnt_vld);
      end
    end
    gnt_rdy = 1'b1;
    tick();
    n_checks++;
    if (gnt_oht !== 4'b0001 || gnt_vld !== 1'b1 || gnt_bin !== 2'd0) begin
      n_fail++;
      $display("FAIL stall_release: oht=%b bin=%0d vld=%b, want 0001 0 1", gnt_oht, gnt_bin,
               gnt_vld);
    end
  endtask

  task automatic test_lock();
    apply_reset();
    req = 4'b0110;
    lck = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (gnt_bin !== 2'd1 || gnt_oht !== 4'b0010 || gnt_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL lock_hold_c%0d: bin=%0d oht=%b vld=%b, want 1 0010 1", c, gnt_bin,
                 gnt_oht, gnt_vld);
      end
    end
    lck = 1'b0;
    tick();
    n_checks++;
    if (gnt_bin !== 2'd2 || gnt_oht !== 4'b0100 || gnt_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_release: bin=%0d oht=%b vld=%b, want 2 0100 1", gnt_bin, gnt_oht,
               gnt_vld);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req     = 4'b0100;
    gnt_rdy = 1'b0;
    tick();
    n_checks++;
    if (gnt_vld !== 1'b1 || gnt_oht !== 4'b0100) begin
      n_fail++;
      $display("FAIL async_setup: oht=%b vld=%b, want 0100 1", gnt_oht, gnt_vld);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt_oht !== '0 || gnt_bin !== '0 || gnt_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: oht=%b bin=%0d vld=%b, want 0 0 0", gnt_oht, gnt_bin, gnt_vld);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    req     = 4'b1000;
    gnt_rdy = 1'b1;
    tick();
    n_checks++;
    if (gnt_bin !== 2'd3 || gnt_oht !== 4'b1000 || gnt_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL async_first_grant: bin=%0d oht=%b vld=%b, want 3 1000 1", gnt_bin, gnt_oht,
               gnt_vld);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      lck     = ($urandom_range(0, 3) == 0);
      gnt_rdy = ($urandom_range(0, 9) < 7);
      tick();
      n_checks++;
      if (gnt_oht !== m_oht || gnt_bin !== m_bin || gnt_vld !== m_vld ||
          (gnt_vld ? !$onehot(gnt_oht) : (gnt_oht !== '0))) begin
        n_fail++;
        $display("FAIL random_c%0d: oht=%b bin=%0d vld=%b, want %b %0d %b", c, gnt_oht, gnt_bin,
                 gnt_vld, m_oht, m_bin, m_vld);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    lck     = 1'b0;
    gnt_rdy = 1'b1;
    model_reset();
    test_reset();
    test_fairness();
    test_mask_wrap();
    test_stall();
    test_lock();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pry_arb_rr.md
# pry_arb_rr

Round-robin arbiter built on the rightmost-priority selection used across this library. Each cycle it masks the request vector with a rotating priority pointer, picks the rightmost active request (falling back to the unmasked vector on wrap), and registers the winner as one-hot plus binary index behind a valid/ready output handshake. It sits directly upstream of consumers that expect a single one-hot grant, such as mux select or one-hot to binary stages, and replaces ad-hoc fixed-priority selection where fairness is required.

## Interface
- `WIDTH`, 8: number of requesters, must be at least 2.
- `WIDTH_LOG`, `$clog2(WIDTH)`: binary index width (local).
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset; asynchronous, active-low.
- `req` input WIDTH: request vector, bit i = requester i.
- `lck` input 1: lock; re-grant the current winner on its next arbitration if it still requests.
- `gnt_oht` output WIDTH: registered one-hot grant.
- `gnt_bin` output WIDTH_LOG: registered binary index of `gnt_oht`.
- `gnt_vld` output 1: grant valid.
- `gnt_rdy` input 1: consumer accepts the grant.

## Operation
- Internal state:
  - `msk[WIDTH-1:0]`, the priority mask.
  - `lst[WIDTH-1:0]`, the one-hot last winner.
- Load condition: `ld = ~gnt_vld | gnt_rdy`, meaning the output register is empty or is being consumed this cycle.
- Selection, evaluated combinationally every cycle:
  - `req_m = req & msk`.
  - If `lck` is 1 and `req & lst` is nonzero, `sel = lst`.
  - Otherwise, if `req_m` is nonzero, `sel` = rightmost set bit of `req_m`.
  - Otherwise, `sel` = rightmost set bit of `req`.
- Rightmost-bit isolation uses the two's-complement identity `x & -x`.
  - The operand is WIDTH bits wide; the carry is discarded.
  - `sel` is zero if `req` is zero.
- On `ld` with `req` nonzero:
  - `gnt_oht <= sel` and `gnt_bin <= index(sel)`; `gnt_vld <= 1`; `lst <= sel`.
  - `msk` is set to the bits strictly above the `sel` index: `msk <= ~((sel << 1) - 1)`, truncated to WIDTH bits.
  - If the `sel` index is WIDTH-1, `msk` becomes 0, so the next arbitration falls back to unmasked, which is the wrap-around.
- On `ld` with `req` zero:
  - `gnt_vld <= 0` and `gnt_oht <= 0`.
  - `gnt_bin`, `msk` and `lst` are held.
- Stall (`gnt_vld & ~gnt_rdy`):
  - `gnt_oht`, `gnt_bin`, `gnt_vld`, `msk` and `lst` are all held.
  - `req` and `lck` changes are ignored, and a registered grant is never withdrawn.
- A requester dropping `req` while its grant is stalled does not cancel the grant; the consumer sees it.
- `lck` with a locked requester no longer requesting: normal round-robin from `msk` applies.
- Invariants:
  - `gnt_oht` is one-hot whenever `gnt_vld` is 1, and all-zero when `gnt_vld` is 0.
  - `gnt_bin` equals the index of `gnt_oht` whenever `gnt_vld` is 1.
- Binary encode is an OR-reduction per index bit over `sel`; no priority logic.

## Timing
- Reset, asynchronous and immediate on `rst_n` low:
  - `gnt_oht = 0`, `gnt_bin = 0`, `gnt_vld = 0`.
  - `msk` = all ones, `lst = 0`.
- First arbitration: on the first rising edge after `rst_n` is released with `req` nonzero.
- Latency: 1 cycle, from `req` sampled to `gnt_vld`/`gnt_oht` visible.
- Throughput: one grant per cycle while `gnt_rdy` is held at 1.
- Handshake:
  - A transfer occurs on an edge where `gnt_vld & gnt_rdy` is 1.
  - On that same edge a new grant is loaded, so there is no bubble.
  - `gnt_rdy` may depend combinationally on `gnt_oht`; `gnt_vld` does not depend on `gnt_rdy` in the same cycle.
- No combinational path from `req`, `lck` or `gnt_rdy` to any output.
- Reset asserted mid-stall: the grant is dropped and the mask is reinitialised; no partial transfer is reported.

## Test plan
- Reset and idle (WIDTH=4): hold `rst_n=0` then release, `req=0` → all outputs 0 for 10 cycles.
- Fairness: `req=4'b1111`, `gnt_rdy=1`, `lck=0` → `gnt_bin` sequence 0,1,2,3,0,1 starting 1 cycle after `req`; every `gnt_oht` is one-hot.
- Masking and wrap:
  - Sequence: `req=4'b1010` → grant 1; then `req=4'b0011` → grant at index 0 via the wrap fallback.
  - After a grant of index 3, `req=4'b1001` → next grant is 0.
- Stall: while a grant of index 2 is stalled, hold `gnt_rdy=0` for 5 cycles and change `req` to `4'b0001` → outputs stay `gnt_oht=4'b0100` and `gnt_vld=1`. After `gnt_rdy=1`, the next grant is 0.
- Lock: `req=4'b0110`, `lck=1` → grant 1 repeated every cycle. Drop `lck` → next grant is 2.
- Async reset during `gnt_vld=1` → outputs go to 0 immediately, without waiting for a clock edge. After release with `req=4'b1000`, the first grant is 3.
